// File: rtl/reg_file_dump.sv
// reg_file_dump: 8 x 16-bit register file with one synchronous write port,
// two combinational read ports and a dump sequencer that streams every
// register, in address order, over a valid/ready handshake.
module reg_file_dump #(
    parameter int DW   = 16,
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic          CLK,
    input  logic          CLR_n,
    input  logic          WE,
    input  logic [AW-1:0] WA,
    input  logic [DW-1:0] WD,
    input  logic [AW-1:0] RA0,
    output logic [DW-1:0] RD0,
    input  logic [AW-1:0] RA1,
    output logic [DW-1:0] RD1,
    input  logic          DUMP_START,
    input  logic          DUMP_READY,
    output logic          DUMP_VALID,
    output logic [AW-1:0] DUMP_ADDR,
    output logic [DW-1:0] DUMP_DATA,
    output logic          DUMP_BUSY,
    output logic          DUMP_DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);
    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
    localparam logic [DW-1:0] ZERO_DATA = {DW{1'b0}};

    logic [DW-1:0] regs_r [NREG];

    state_t        state_r;
    state_t        state_nxt_s;
    logic          dump_valid_r;
    logic          dump_valid_nxt_s;
    logic [AW-1:0] dump_addr_r;
    logic [AW-1:0] dump_addr_nxt_s;
    logic [AW-1:0] dump_addr_inc_s;
    logic [DW-1:0] dump_data_r;
    logic [DW-1:0] dump_data_nxt_s;
    logic          dump_busy_r;
    logic          dump_busy_nxt_s;
    logic          dump_done_r;
    logic          dump_done_nxt_s;

    // Reads see the stored value only; a write lands at the edge (no bypass).
    assign RD0 = regs_r[RA0];
    assign RD1 = regs_r[RA1];

    assign dump_addr_inc_s = dump_addr_r + {{(AW-1){1'b0}}, 1'b1};

    assign DUMP_VALID = dump_valid_r;
    assign DUMP_ADDR  = dump_addr_r;
    assign DUMP_DATA  = dump_data_r;
    assign DUMP_BUSY  = dump_busy_r;
    assign DUMP_DONE  = dump_done_r;

    // Register array: cleared by reset, single write port.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (WE) begin
            regs_r[WA] <= WD;
        end
    end

    // Dump sequencer state and registered handshake outputs.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_r      <= ST_IDLE;
            dump_valid_r <= 1'b0;
            dump_addr_r  <= ZERO_ADDR;
            dump_data_r  <= ZERO_DATA;
            dump_busy_r  <= 1'b0;
            dump_done_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dump_valid_r <= dump_valid_nxt_s;
            dump_addr_r  <= dump_addr_nxt_s;
            dump_data_r  <= dump_data_nxt_s;
            dump_busy_r  <= dump_busy_nxt_s;
            dump_done_r  <= dump_done_nxt_s;
        end
    end

    // Next-state and next-output logic; data is captured from the pre-write
    // array so a beat reflects the register at its capture edge.
    always_comb begin
        state_nxt_s      = state_r;
        dump_valid_nxt_s = dump_valid_r;
        dump_addr_nxt_s  = dump_addr_r;
        dump_data_nxt_s  = dump_data_r;
        dump_busy_nxt_s  = dump_busy_r;
        dump_done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dump_addr_nxt_s = ZERO_ADDR;
                if (DUMP_START) begin
                    state_nxt_s      = ST_SEND;
                    dump_data_nxt_s  = regs_r[0];
                    dump_valid_nxt_s = 1'b1;
                    dump_busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s      = ST_IDLE;
                    dump_valid_nxt_s = 1'b0;
                    dump_busy_nxt_s  = 1'b0;
                end
            end
            ST_SEND: begin
                if (DUMP_READY) begin
                    if (dump_addr_r == LAST_ADDR) begin
                        state_nxt_s      = ST_DONE;
                        dump_valid_nxt_s = 1'b0;
                        dump_busy_nxt_s  = 1'b0;
                        dump_done_nxt_s  = 1'b1;
                    end else begin
                        dump_addr_nxt_s = dump_addr_inc_s;
                        dump_data_nxt_s = regs_r[dump_addr_inc_s];
                    end
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_nxt_s      = ST_IDLE;
                dump_valid_nxt_s = 1'b0;
                dump_busy_nxt_s  = 1'b0;
                dump_addr_nxt_s  = ZERO_ADDR;
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                dump_valid_nxt_s = 1'b0;
                dump_busy_nxt_s  = 1'b0;
                dump_addr_nxt_s  = ZERO_ADDR;
                dump_data_nxt_s  = ZERO_DATA;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_file_dump.sv
// Testbench for reg_file_dump: directed scenarios plus random traffic,
// dump beats checked through a scoreboard queue against a bench model.
module tb_reg_file_dump;

    logic        CLK = 1'b0;
    logic        CLR_n;
    logic        WE;
    logic [2:0]  WA;
    logic [15:0] WD;
    logic [2:0]  RA0;
    logic [15:0] RD0;
    logic [2:0]  RA1;
    logic [15:0] RD1;
    logic        DUMP_START;
    logic        DUMP_READY;
    logic        DUMP_VALID;
    logic [2:0]  DUMP_ADDR;
    logic [15:0] DUMP_DATA;
    logic        DUMP_BUSY;
    logic        DUMP_DONE;

    int checks = 0;
    int errors = 0;

    // bench model: register contents and dump progress
    int mdl_regs [8];
    bit mdl_busy;
    bit mdl_done;
    int mdl_idx;
    int exp_addr [$];
    int exp_data [$];

    reg_file_dump #(.DW(16), .AW(3), .NREG(8)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .WE(WE), .WA(WA), .WD(WD),
        .RA0(RA0), .RD0(RD0), .RA1(RA1), .RD1(RD1),
        .DUMP_START(DUMP_START), .DUMP_READY(DUMP_READY),
        .DUMP_VALID(DUMP_VALID), .DUMP_ADDR(DUMP_ADDR), .DUMP_DATA(DUMP_DATA),
        .DUMP_BUSY(DUMP_BUSY), .DUMP_DONE(DUMP_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every beat accepted by the sink must match the next expected beat
    always @(negedge CLK) begin
        if (CLR_n && DUMP_VALID && DUMP_READY) begin
            if (exp_addr.size() == 0) begin
                chk("beat_unexpected", 1, 0);
            end else begin
                chk("beat_addr", int'(DUMP_ADDR), exp_addr.pop_front());
                chk("beat_data", int'(DUMP_DATA), exp_data.pop_front());
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mdl_regs[i] = 0;
        mdl_busy = 0;
        mdl_done = 0;
        mdl_idx  = 0;
        exp_addr.delete();
        exp_data.delete();
    endtask

    // one clock: drive inputs, check pre-edge state, advance model, take the edge
    task automatic step(input bit we, input int wa, input int wd,
                        input int ra0, input int ra1, input bit start, input bit ready);
        bit next_done;
        WE = we; WA = 3'(wa); WD = 16'(wd);
        RA0 = 3'(ra0); RA1 = 3'(ra1);
        DUMP_START = start; DUMP_READY = ready;
        #1;
        chk("rd0", int'(RD0), mdl_regs[ra0]);
        chk("rd1", int'(RD1), mdl_regs[ra1]);
        chk("valid", int'(DUMP_VALID), int'(mdl_busy));
        chk("busy", int'(DUMP_BUSY), int'(mdl_busy));
        chk("done", int'(DUMP_DONE), int'(mdl_done));
        if (!mdl_busy) chk("idle_addr", int'(DUMP_ADDR), mdl_done ? 7 : 0);
        next_done = 0;
        if (mdl_busy) begin
            if (ready) begin
                if (mdl_idx < 7) begin
                    mdl_idx++;
                    exp_addr.push_back(mdl_idx);
                    exp_data.push_back(mdl_regs[mdl_idx]);
                end else begin
                    mdl_busy  = 0;
                    next_done = 1;
                end
            end
        end else if (!mdl_done && start) begin
            mdl_busy = 1;
            mdl_idx  = 0;
            exp_addr.push_back(0);
            exp_data.push_back(mdl_regs[0]);
        end
        mdl_done = next_done;
        if (we) mdl_regs[wa] = wd & 16'hFFFF;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, i % 8, 7 - (i % 8), 1'b0, ready);
    endtask

    // asynchronous reset assertion mid-cycle, held for two edges
    task automatic do_reset();
        #1;
        CLR_n = 1'b0;
        #1;
        chk("rst_rd0", int'(RD0), 0);
        chk("rst_rd1", int'(RD1), 0);
        chk("rst_valid", int'(DUMP_VALID), 0);
        chk("rst_busy", int'(DUMP_BUSY), 0);
        chk("rst_done", int'(DUMP_DONE), 0);
        chk("rst_addr", int'(DUMP_ADDR), 0);
        chk("rst_data", int'(DUMP_DATA), 0);
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        CLR_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CLR_n = 1'b0;
        WE = 1'b0; WA = 3'd0; WD = 16'd0; RA0 = 3'd0; RA1 = 3'd0;
        DUMP_START = 1'b0; DUMP_READY = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        chk("por_valid", int'(DUMP_VALID), 0);
        chk("por_busy", int'(DUMP_BUSY), 0);
        CLR_n = 1'b1;
        idle(8, 1'b0);

        // write/read and no-bypass behaviour
        step(1'b1, 3, 60001, 3, 3, 1'b0, 1'b0);
        step(1'b0, 3, 17, 3, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 3, 3, 1'b0, 1'b0);
        step(1'b1, 5, 320, 5, 5, 1'b0, 1'b0);
        step(1'b0, 0, 0, 5, 3, 1'b0, 1'b0);

        // load then reset with data present, all reads back to zero
        for (int k = 0; k < 8; k++) step(1'b1, k, 1000 + k, k, 0, 1'b0, 1'b0);
        do_reset();
        idle(8, 1'b0);

        // full dump with ready held high
        for (int k = 0; k < 8; k++) step(1'b1, k, 100 + k, 0, 1, 1'b0, 1'b1);
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(11, 1'b1);

        // backpressure on beat 2, write-ahead on reg 6, ignored mid-dump start
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 1, 2, 1'b0, 1'b1);
        step(1'b1, 6, 51210, 6, 2, 1'b1, 1'b1);
        step(1'b1, 2, 51234, 2, 6, 1'b0, 1'b0);
        step(1'b0, 0, 0, 2, 6, 1'b1, 1'b0);
        step(1'b0, 0, 0, 2, 6, 1'b0, 1'b0);
        idle(9, 1'b1);

        // start held high across DONE restarts once back in IDLE
        for (int i = 0; i < 24; i++) step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(10, 1'b1);

        // reset while beat 4 is presented: abort, no DONE, restart from 0
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(4, 1'b1);
        chk("pre_abort_addr", int'(DUMP_ADDR), 4);
        do_reset();
        idle(4, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b1, k, 200 + k, k, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(11, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom_range(0, 65535),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
        end
        idle(30, 1'b1);

        chk("scoreboard_drained", exp_addr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
